// File: rtl/lag_vc_blocked_tracker_pkg.sv
// Shared definitions for the LAG per-VC blocked-status tracker.
//   link_cnt_t            per-trunk {IN, OUT} link counts
//   IN / OUT              indices into link_cnt_t
//   LAG_route_valid_turn  1 when traffic entering on in_port may leave on out_port.
//                         A U-turn (leaving on the port it arrived on) is the only
//                         forbidden turn.
package lag_vc_blocked_tracker_pkg;

  typedef int unsigned link_cnt_t [2];

  localparam int unsigned IN  = 0;
  localparam int unsigned OUT = 1;

  function automatic logic LAG_route_valid_turn(input int unsigned in_port,
                                                input int unsigned out_port);
    return in_port != out_port;
  endfunction

endpackage

// File: rtl/lag_vc_sel_mask.sv
// Combinational blocked-bit select for one VC.
// Picks blocked_in[i*WB+j] for every selected trunk i / link j, ignoring links
// beyond the trunk's OUT link count and trunks that are an invalid turn from
// input_port, and ORs the result.
// Ports:
//   sel_a       unary trunk select for this VC
//   sel_b       unary link select for this VC
//   blocked_in  blocked bit of trunk i link j at [i*WB+j]
//   sel         selected, masked blocked status
module lag_vc_sel_mask import lag_vc_blocked_tracker_pkg::*; #(
  parameter int unsigned input_port = 0,
  parameter int unsigned WA         = 5,
  parameter int unsigned WB         = 2,
  parameter link_cnt_t   links [WA] = '{default: '{default: 2}}
) (
  input  logic [WA-1:0]    sel_a,
  input  logic [WB-1:0]    sel_b,
  input  logic [WA*WB-1:0] blocked_in,
  output logic             sel
);

  // valid_mask is a constant per build; only pick depends on the VC's selection.
  logic [WA*WB-1:0] valid_mask;
  logic [WA*WB-1:0] pick;

  for (genvar gi = 0; gi < WA; gi++) begin : g_trunk
    for (genvar gj = 0; gj < WB; gj++) begin : g_link
      assign valid_mask[gi*WB+gj] = (gj < links[gi][OUT]) &&
                                    LAG_route_valid_turn(input_port, gi);
      assign pick[gi*WB+gj]       = sel_a[gi] & sel_b[gj];
    end
  end

  assign sel = |(blocked_in & valid_mask & pick);

endmodule

// File: rtl/lag_vc_blocked_tracker.sv
// Per-VC blocked-status tracker for a LAG router input port.
// For each VC: registers the masked blocked bit of its selected (trunk, link),
// counts consecutive blocked cycles on the current selection (saturating) and
// flags starvation once the count reaches STARVE_THRESH.
// Optional build macro LAG_SEL_ONEHOT_CHECK_EN: flags non-one-hot selections on
// sel_err, reports such a VC as blocked and freezes its age. Without it sel_err
// is 0 and multi-hot selects simply OR the selected bits.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   vc_req        VC holds a route/allocation
//   sel_a, sel_b  per-VC unary trunk / link selects
//   blocked_in    output-side blocked vector, trunk i link j at [i*WB+j]
//   vc_blocked    registered selected blocked status
//   vc_block_age  consecutive blocked cycles, VC v at [v*AGE_W +: AGE_W]
//   vc_starved    vc_block_age >= STARVE_THRESH
//   sel_err       selection not one-hot (macro builds only)
module lag_vc_blocked_tracker import lag_vc_blocked_tracker_pkg::*; #(
  parameter int unsigned input_port    = 0,
  parameter int unsigned NUM_VC        = 4,
  parameter int unsigned WA            = 5,
  parameter int unsigned WB            = 2,
  parameter link_cnt_t   links [WA]    = '{default: '{default: 2}},
  parameter int unsigned AGE_W         = 4,
  parameter int unsigned STARVE_THRESH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_VC-1:0]       vc_req,
  input  logic [NUM_VC*WA-1:0]    sel_a,
  input  logic [NUM_VC*WB-1:0]    sel_b,
  input  logic [WA*WB-1:0]        blocked_in,
  output logic [NUM_VC-1:0]       vc_blocked,
  output logic [NUM_VC*AGE_W-1:0] vc_block_age,
  output logic [NUM_VC-1:0]       vc_starved,
  output logic [NUM_VC-1:0]       sel_err
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] THRESH  = AGE_W'(STARVE_THRESH);

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
    logic [WA-1:0]    cur_a;
    logic [WB-1:0]    cur_b;
    logic             sel_v;
    logic             err_v;
    logic             sel_changed;
    logic             blocked_reg, blocked_next;
    logic             err_reg;
    logic [AGE_W-1:0] age_reg, age_next;
    logic [WA-1:0]    sa_reg, sa_next;
    logic [WB-1:0]    sb_reg, sb_next;

    assign cur_a = sel_a[gi*WA +: WA];
    assign cur_b = sel_b[gi*WB +: WB];

    lag_vc_sel_mask #(
      .input_port (input_port),
      .WA         (WA),
      .WB         (WB),
      .links      (links)
    ) u_sel_mask (
      .sel_a      (cur_a),
      .sel_b      (cur_b),
      .blocked_in (blocked_in),
      .sel        (sel_v)
    );

`ifdef LAG_SEL_ONEHOT_CHECK_EN
    assign err_v = vc_req[gi] & ~($onehot(cur_a) & $onehot(cur_b));
`else
    assign err_v = 1'b0;
`endif

    assign sel_changed = (cur_a != sa_reg) || (cur_b != sb_reg);

    always_comb begin
      blocked_next = vc_req[gi] & sel_v;
      age_next     = age_reg;
      sa_next      = sa_reg;
      sb_next      = sb_reg;
      if (!vc_req[gi]) begin
        age_next = '0;
        sa_next  = '0;
        sb_next  = '0;
      end else if (err_v) begin
        // Malformed selection: report blocked, freeze age and stored selection.
        blocked_next = 1'b1;
      end else if (sel_changed) begin
        // New route: age restarts from this cycle's blocked status.
        age_next = {{(AGE_W-1){1'b0}}, sel_v};
        sa_next  = cur_a;
        sb_next  = cur_b;
      end else if (sel_v) begin
        age_next = (age_reg == AGE_MAX) ? age_reg : age_reg + 1'b1;
      end else begin
        age_next = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        blocked_reg <= 1'b0;
        err_reg     <= 1'b0;
        age_reg     <= '0;
        sa_reg      <= '0;
        sb_reg      <= '0;
      end else begin
        blocked_reg <= blocked_next;
        err_reg     <= err_v;
        age_reg     <= age_next;
        sa_reg      <= sa_next;
        sb_reg      <= sb_next;
      end
    end

    assign vc_blocked[gi]                  = blocked_reg;
    assign vc_block_age[gi*AGE_W +: AGE_W] = age_reg;
    assign vc_starved[gi]                  = (age_reg >= THRESH);
    assign sel_err[gi]                     = err_reg;
  end

endmodule

// File: tb/tb_lag_vc_blocked_tracker.sv
// Self-checking bench for lag_vc_blocked_tracker: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model (saturating per-VC blocked counters keyed on the route).
module tb_lag_vc_blocked_tracker;
  import lag_vc_blocked_tracker_pkg::*;

  localparam int NUM_VC = 4;
  localparam int WA     = 5;
  localparam int WB     = 2;
  localparam int AGE_W  = 4;
  localparam int THR    = 8;
  localparam int AMAX   = 15;
  localparam int IPORT  = 0;
  localparam link_cnt_t LINKS [WA] = '{'{2, 2}, '{2, 2}, '{2, 1}, '{2, 2}, '{2, 2}};

  logic                    clk;
  logic                    rst_n;
  logic [NUM_VC-1:0]       vc_req;
  logic [NUM_VC*WA-1:0]    sel_a;
  logic [NUM_VC*WB-1:0]    sel_b;
  logic [WA*WB-1:0]        blocked_in;
  logic [NUM_VC-1:0]       vc_blocked;
  logic [NUM_VC*AGE_W-1:0] vc_block_age;
  logic [NUM_VC-1:0]       vc_starved;
  logic [NUM_VC-1:0]       sel_err;

  int n_checks = 0;
  int n_fail   = 0;

  lag_vc_blocked_tracker #(
    .input_port    (IPORT),
    .NUM_VC        (NUM_VC),
    .WA            (WA),
    .WB            (WB),
    .links         (LINKS),
    .AGE_W         (AGE_W),
    .STARVE_THRESH (THR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vc_req       (vc_req),
    .sel_a        (sel_a),
    .sel_b        (sel_b),
    .blocked_in   (blocked_in),
    .vc_blocked   (vc_blocked),
    .vc_block_age (vc_block_age),
    .vc_starved   (vc_starved),
    .sel_err      (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_age [NUM_VC];
  int m_blk [NUM_VC];
  int m_err [NUM_VC];
  int m_sa  [NUM_VC];
  int m_sb  [NUM_VC];

  initial begin
    for (int v = 0; v < NUM_VC; v++) begin
      m_age[v] = 0; m_blk[v] = 0; m_err[v] = 0; m_sa[v] = 0; m_sb[v] = 0;
    end
  end

  // Is the VC's chosen (trunk, link) blocked? A route is usable only if the link
  // exists on that trunk and the trunk is not a U-turn back to this input port.
  function automatic int model_sel(int v);
    int r = 0;
    for (int i = 0; i < WA; i++)
      for (int j = 0; j < WB; j++)
        if (sel_a[v*WA+i] && sel_b[v*WB+j] && j < int'(LINKS[i][OUT]) &&
            i != IPORT && blocked_in[i*WB+j])
          r = 1;
    return r;
  endfunction

  function automatic int model_err(int v);
    int e = 0;
`ifdef LAG_SEL_ONEHOT_CHECK_EN
    if (vc_req[v] && ($countones(sel_a[v*WA +: WA]) != 1 || $countones(sel_b[v*WB +: WB]) != 1))
      e = 1;
`endif
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        m_age[v] <= 0; m_blk[v] <= 0; m_err[v] <= 0; m_sa[v] <= 0; m_sb[v] <= 0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        int s, e, a, b;
        s = model_sel(v);
        e = model_err(v);
        a = int'(sel_a[v*WA +: WA]);
        b = int'(sel_b[v*WB +: WB]);
        m_err[v] <= e;
        if (!vc_req[v]) begin
          m_blk[v] <= 0; m_age[v] <= 0; m_sa[v] <= 0; m_sb[v] <= 0;
        end else if (e != 0) begin
          m_blk[v] <= 1;
        end else begin
          m_blk[v] <= s;
          if (a != m_sa[v] || b != m_sb[v]) begin
            m_age[v] <= s; m_sa[v] <= a; m_sb[v] <= b;
          end else if (s != 0) begin
            m_age[v] <= (m_age[v] + 1 > AMAX) ? AMAX : m_age[v] + 1;
          end else begin
            m_age[v] <= 0;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int age_of(int v);
    return int'(vc_block_age[v*AGE_W +: AGE_W]);
  endfunction

  always @(negedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      chk($sformatf("model vc%0d blocked", v), int'(vc_blocked[v]), m_blk[v]);
      chk($sformatf("model vc%0d age", v), age_of(v), m_age[v]);
      chk($sformatf("model vc%0d starved", v), int'(vc_starved[v]), (m_age[v] >= THR) ? 1 : 0);
      chk($sformatf("model vc%0d sel_err", v), int'(sel_err[v]), m_err[v]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    vc_req = '0; sel_a = '0; sel_b = '0; blocked_in = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    clear_inputs();
    cyc(2);
    chk("reset blocked", int'(vc_blocked), 0);
    chk("reset age", int'(vc_block_age), 0);
    chk("reset starved", int'(vc_starved), 0);
    chk("reset sel_err", int'(sel_err), 0);
    rst_n = 1'b1;
    cyc(1);

    // 1: trunk 2 link 0 blocked, ages up, starves at 8, saturates at 15
    vc_req = 4'b0001; sel_a[4:0] = 5'b00100; sel_b[1:0] = 2'b01; blocked_in = 10'b00000_10000;
    cyc(1);
    chk("t1 blocked", int'(vc_blocked[0]), 1);
    chk("t1 age1", age_of(0), 1);
    cyc(6);
    chk("t1 age7", age_of(0), 7);
    chk("t1 not starved at 7", int'(vc_starved[0]), 0);
    cyc(1);
    chk("t1 starved at 8", int'(vc_starved[0]), 1);
    cyc(10);
    chk("t1 saturate", age_of(0), 15);

    // 2: link 1 of trunk 2 does not exist
    sel_b[1:0] = 2'b10; blocked_in = 10'b00001_00000;
    cyc(1);
    chk("t2 masked link", int'(vc_blocked[0]), 0);
    chk("t2 age", age_of(0), 0);

    // 3: trunk 0 is a U-turn from input port 0
    sel_a[4:0] = 5'b00001; sel_b[1:0] = 2'b01; blocked_in = 10'b00000_00001;
    cyc(1);
    chk("t3 invalid turn", int'(vc_blocked[0]), 0);

    // 4: reroute while blocked restarts age, single unblock clears it
    sel_a[4:0] = 5'b00010; sel_b[1:0] = 2'b01; blocked_in = 10'b00000_01100;
    cyc(6);
    chk("t4 age6", age_of(0), 6);
    sel_b[1:0] = 2'b10;
    cyc(1);
    chk("t4 reroute age", age_of(0), 1);
    chk("t4 reroute starved", int'(vc_starved[0]), 0);
    chk("t4 reroute blocked", int'(vc_blocked[0]), 1);
    blocked_in = '0;
    cyc(1);
    chk("t4 unblock age", age_of(0), 0);
    chk("t4 unblock blocked", int'(vc_blocked[0]), 0);

    // 5: VC1 request drop at age 12, then asynchronous reset mid-count
    clear_inputs();
    vc_req = 4'b0010; sel_a[9:5] = 5'b00010; sel_b[3:2] = 2'b01; blocked_in = 10'b00000_00100;
    cyc(12);
    chk("t5 age12", age_of(1), 12);
    chk("t5 starved12", int'(vc_starved[1]), 1);
    vc_req = 4'b0000;
    cyc(1);
    chk("t5 drop age", age_of(1), 0);
    chk("t5 drop blocked", int'(vc_blocked[1]), 0);
    chk("t5 drop starved", int'(vc_starved[1]), 0);
    vc_req = 4'b0010;
    cyc(5);
    chk("t5 regrow", age_of(1), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 async rst blocked", int'(vc_blocked), 0);
    chk("t5 async rst age", int'(vc_block_age), 0);
    chk("t5 async rst starved", int'(vc_starved), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    chk("t5 post-reset age", age_of(1), 1);

    // 6: multi-hot trunk select on VC2
    clear_inputs();
    vc_req = 4'b0100; sel_a[14:10] = 5'b00110; sel_b[5:4] = 2'b01; blocked_in = 10'b00000_00100;
    cyc(1);
    chk("t6 blocked", int'(vc_blocked[2]), 1);
`ifdef LAG_SEL_ONEHOT_CHECK_EN
    chk("t6 sel_err", int'(sel_err[2]), 1);
    chk("t6 age held", age_of(2), 0);
`else
    chk("t6 sel_err", int'(sel_err[2]), 0);
    chk("t6 age", age_of(2), 1);
`endif
    blocked_in = '0;
    cyc(1);
`ifdef LAG_SEL_ONEHOT_CHECK_EN
    chk("t6 conservative", int'(vc_blocked[2]), 1);
`else
    chk("t6 or of none", int'(vc_blocked[2]), 0);
`endif

    // Random traffic: sticky routes and mostly-blocked links so ages grow
    clear_inputs();
    for (int c = 0; c < 3000; c++) begin
      for (int v = 0; v < NUM_VC; v++) begin
        if ($urandom_range(0, 24) == 0) vc_req[v] = ~vc_req[v];
        if ($urandom_range(0, 11) == 0) begin
          if ($urandom_range(0, 7) == 0) begin
            sel_a[v*WA +: WA] = WA'($urandom);
            sel_b[v*WB +: WB] = WB'($urandom);
          end else begin
            sel_a[v*WA +: WA] = WA'(1) << $urandom_range(0, WA-1);
            sel_b[v*WB +: WB] = WB'(1) << $urandom_range(0, WB-1);
          end
        end
      end
      if ($urandom_range(0, 5) == 0)
        for (int k = 0; k < WA*WB; k++) blocked_in[k] = ($urandom_range(0, 9) < 8);
      if (c % 700 == 699) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
